// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_pkg
// Brief   : Shared types and default sizing for the load/store sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam int c_BITS   = 8;
    localparam int c_ADDR_W = 3;
    localparam int c_QDEPTH = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_ADDR = 3'd2,
        RD_CAP  = 3'd3,
        RSP     = 3'd4
    } state_t;

    typedef struct packed {
        logic                we;
        logic [c_ADDR_W-1:0] addr;
        logic [c_BITS-1:0]   wdata;
    } lsu_op_t;

    localparam int c_OP_W = $bits(lsu_op_t);

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
// Module  : lsu_if
// Brief   : Request, response and memory-pin bundle around lsu_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
interface lsu_if #(
    parameter int BITS   = lsu_pkg::c_BITS,
    parameter int ADDR_W = lsu_pkg::c_ADDR_W
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [BITS-1:0]   req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [BITS-1:0]   rsp_rdata;

    logic [BITS-1:0]   mem_datain;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_en;
    logic [BITS-1:0]   mem_dataout;

    logic              busy;

    // lsu_ctrl side
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        input  rsp_ready,
        input  mem_dataout,
        output req_ready,
        output rsp_valid, rsp_rdata,
        output mem_datain, mem_address, mem_en,
        output busy
    );

    // core + memory side
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        output rsp_ready,
        output mem_dataout,
        input  req_ready,
        input  rsp_valid, rsp_rdata,
        input  mem_datain, mem_address, mem_en,
        input  busy
    );

endinterface
`default_nettype wire

// File: rtl/lsu_req_fifo.sv
`default_nettype none
// ============================================================================
// Module  : lsu_req_fifo
// Brief   : In-order request queue with registered count and wrapping pointers.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 12
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       push,
    input  wire logic [WIDTH-1:0]           push_data,
    input  wire logic                       pop,
    output logic      [WIDTH-1:0]           head,
    output logic                            full,
    output logic                            empty,
    output logic      [$clog2(DEPTH):0]     count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign full      = (r_count == c_CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rptr];
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : lsu_ctrl
// Brief   : Load/store sequencer driving an 8-entry registered-output memory.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_ctrl
    import lsu_pkg::*;
#(
    // BITS and ADDR_W must match the lsu_op_t layout in lsu_pkg
    parameter int BITS   = c_BITS,
    parameter int ADDR_W = c_ADDR_W,
    parameter int QDEPTH = c_QDEPTH
) (
    input  wire logic clk,
    input  wire logic reset,
    lsu_if.slave      bus
);

    state_t  r_state;
    state_t  w_state_nxt;
    lsu_op_t r_op;
    lsu_op_t w_op_nxt;
    lsu_op_t w_req_op;
    lsu_op_t w_head;

    logic              r_live;
    logic              r_rsp_valid;
    logic              w_rsp_valid_nxt;
    logic [BITS-1:0]   r_rsp_rdata;
    logic [BITS-1:0]   w_rsp_rdata_nxt;

    logic                     w_push;
    logic                     w_pop;
    logic [c_OP_W-1:0]        w_fifo_head;
    logic                     w_full;
    logic                     w_empty;
    logic [$clog2(QDEPTH):0]  w_count;

    // r_live keeps req_ready low throughout reset and rises on the first edge after release
    assign bus.req_ready = r_live && !w_full;
    assign w_push        = bus.req_valid && bus.req_ready;

    always_comb begin
        w_req_op       = '0;
        w_req_op.we    = bus.req_we;
        w_req_op.addr  = bus.req_addr;
        w_req_op.wdata = bus.req_wdata;
    end

    lsu_req_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (c_OP_W)
    ) u_req_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_req_op),
        .pop       (w_pop),
        .head      (w_fifo_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign w_head = w_fifo_head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_live      <= 1'b0;
            r_state     <= IDLE;
            r_op        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_live      <= 1'b1;
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_pop           = 1'b0;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_op_nxt    = w_head;
                    w_state_nxt = w_head.we ? WR : RD_ADDR;
                end
            end
            WR: begin
                w_state_nxt = IDLE;
            end
            RD_ADDR: begin
                w_state_nxt = RD_CAP;
            end
            RD_CAP: begin
                // memory registered its output on the edge that ended RD_ADDR
                w_rsp_valid_nxt = 1'b1;
                w_rsp_rdata_nxt = bus.mem_dataout;
                w_state_nxt     = RSP;
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.mem_en      = (r_state == WR);
    assign bus.mem_address = r_op.addr;
    assign bus.mem_datain  = r_op.wdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.busy        = (w_count != '0) || (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_ctrl
// Brief   : Directed bench for lsu_ctrl with a registered-output memory model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lsu_ctrl;

    localparam int c_BITS   = 8;
    localparam int c_ADDR_W = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lsu_if #(.BITS(c_BITS), .ADDR_W(c_ADDR_W)) bus ();

    lsu_ctrl #(.BITS(c_BITS), .ADDR_W(c_ADDR_W), .QDEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 8-entry memory: synchronous write on en, registered read data
    logic [c_BITS-1:0] mem [8] = '{default: '0};
    logic [c_BITS-1:0] mem_q   = '0;
    always @(posedge clk) begin
        if (bus.mem_en === 1'b1) mem[bus.mem_address] <= bus.mem_datain;
        mem_q <= mem[bus.mem_address];
    end
    assign bus.mem_dataout = mem_q;

    int en_cnt = 0;
    always @(negedge clk) if (bus.mem_en === 1'b1) en_cnt++;

    logic [c_BITS-1:0] shadow [8] = '{default: '0};
    logic [c_BITS-1:0] sb [$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // inputs change and outputs are sampled 3 ns after each rising edge
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic send(input logic we, input logic [2:0] a, input logic [7:0] d);
        int waited = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (bus.req_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        if (bus.req_ready !== 1'b1) begin
            check("req_ready_timeout", bus.req_ready, 1);
            bus.req_valid = 1'b0;
            return;
        end
        if (we) shadow[a] = d;
        else    sb.push_back(shadow[a]);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int waited = 0;
        while (bus.rsp_valid !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        check({tag, "_valid"}, bus.rsp_valid, 1);
    endtask

    task automatic get_rsp(input string tag);
        logic [7:0] exp;
        wait_valid(tag);
        if (bus.rsp_valid !== 1'b1) return;
        if (sb.size() == 0) begin
            check({tag, "_sb"}, sb.size(), 1);
            return;
        end
        exp = sb.pop_front();
        check({tag, "_data"}, bus.rsp_rdata, exp);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check({tag, "_clr"}, bus.rsp_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        logic [7:0] old5;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;

        // reset held with a request pending
        tick(3);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_mem_addr", bus.mem_address, 0);
        check("rst_mem_datain", bus.mem_datain, 0);
        check("rst_busy", bus.busy, 0);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        #1 check("rel_req_ready_same", bus.req_ready, 0);
        tick();
        check("rel_req_ready", bus.req_ready, 1);
        check("rel_busy", bus.busy, 0);

        // single store: write strobe in the second cycle after accept only
        send(1'b1, 3'd3, 8'hA5);
        check("st_c1_en", bus.mem_en, 0);
        tick();
        check("st_c2_en", bus.mem_en, 1);
        check("st_c2_addr", bus.mem_address, 3);
        check("st_c2_data", bus.mem_datain, 8'hA5);
        check("st_c2_busy", bus.busy, 1);
        tick();
        check("st_c3_en", bus.mem_en, 0);
        check("st_c3_busy", bus.busy, 0);

        // single load: valid rises on the edge ending the capture cycle
        send(1'b0, 3'd3, 8'h00);
        check("ld_c1_valid", bus.rsp_valid, 0);
        tick();
        check("ld_c2_en", bus.mem_en, 0);
        check("ld_c2_addr", bus.mem_address, 3);
        tick();
        check("ld_c3_valid", bus.rsp_valid, 0);
        tick();
        check("ld_c4_valid", bus.rsp_valid, 1);
        get_rsp("ld");
        check("ld_busy", bus.busy, 0);

        // read after write, back to back
        e0 = en_cnt;
        send(1'b1, 3'd7, 8'h11);
        send(1'b0, 3'd7, 8'h00);
        get_rsp("raw");
        check("raw_en_pulses", en_cnt - e0, 1);

        // backpressure with a full queue
        send(1'b0, 3'd3, 8'h00);
        send(1'b0, 3'd0, 8'h00);
        send(1'b0, 3'd3, 8'h00);
        check("full_req_ready", bus.req_ready, 0);
        wait_valid("bp");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_valid", bus.rsp_valid, 1);
            check("bp_hold_data", bus.rsp_rdata, 8'hA5);
            check("bp_hold_ready", bus.req_ready, 0);
        end
        get_rsp("bp0");
        get_rsp("bp1");
        get_rsp("bp2");
        check("bp_sb_empty", sb.size(), 0);

        // asynchronous reset while a response is pending and a store is queued
        send(1'b0, 3'd7, 8'h00);
        wait_valid("mid");
        old5 = shadow[5];
        send(1'b1, 3'd5, 8'h5A);
        check("mid_busy", bus.busy, 1);
        reset = 1'b0;
        #1;
        check("mid_rsp_valid", bus.rsp_valid, 0);
        check("mid_req_ready", bus.req_ready, 0);
        check("mid_busy_rst", bus.busy, 0);
        check("mid_mem_en", bus.mem_en, 0);
        sb.delete();
        shadow[5] = old5;
        e0 = en_cnt;
        tick();
        reset = 1'b1;
        tick(10);
        check("post_en_pulses", en_cnt - e0, 0);
        check("post_busy", bus.busy, 0);
        check("post_req_ready", bus.req_ready, 1);
        check("post_rsp_valid", bus.rsp_valid, 0);
        send(1'b0, 3'd5, 8'h00);
        get_rsp("post_ld5");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
